spi_ram_burst_slave: RTL and testbench
======================================

Name: spi_ram_burst_slave

Overview:
- Next-generation SPI-slave-plus-single-port-RAM block, driven by the system clock.
- Parametrised in address width, data width and depth.
- Adds auto-incrementing burst writes and burst reads within one SS_n frame, with address wrap-around.
- Flags invalid commands and aborted words.
- Sits at the chip pin boundary as a self-contained memory-mapped slave.

Parameters:
- ADDR_SIZE, 8, address width in bits; also the address field length in the frame.
- DATA_WIDTH, 8, RAM word width; also the burst word length in the frame.
- MEM_DEPTH, 256, number of words. Must be ≤ 2**ADDR_SIZE. The last valid address is MEM_DEPTH-1.

Ports:
- clk  in  1  system clock; all MOSI sampling and MISO updates happen on rising edges.
- rst  in  1  reset, asynchronous, active-high.
- SS_n  in  1  slave select, active-low; a frame lasts while SS_n=0.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first, registered.
- busy  out  1  1 while a frame is being decoded, i.e. state != IDLE.
- err  out  1  one-cycle pulse, registered.

Behaviour:
- Reset:
  - State goes to IDLE; MISO=0, busy=0, err=0; shift registers, bit counter and address pointer cleared.
  - RAM contents are not cleared.
  - Reset asserted mid-frame aborts the frame. After rst deasserts, the block waits in IDLE until SS_n goes high and then low again.
- Cycle numbering: k=0 is the first rising edge with SS_n=0 after SS_n was high.
- Frame layout:
  - k=0..1: 2-bit cmd.
  - k=2..ADDR_SIZE+1: start address.
  - Then payload.
- Commands:
  - 2'b00 WRITE_BURST
  - 2'b01 READ_BURST
  - 2'b10 and 2'b11 reserved.
- States: IDLE, CMD, ADDR, WR_DATA, RD_TURN, RD_DATA, IGNORE.
- Transitions:
  - IDLE->CMD on SS_n=0 (k=0 bit captured).
  - CMD->ADDR after 2 bits.
  - ADDR->WR_DATA or RD_TURN after the last address bit, per cmd.
  - A reserved cmd goes CMD->IGNORE and pulses err on the edge after the cmd is complete.
  - Any state->IDLE on the first edge with SS_n=1, which takes priority over everything else.
- Write burst:
  - DATA_WIDTH bits are shifted in.
  - On the edge sampling the last bit of a word, the RAM writes the word to ptr, and ptr becomes ptr+1.
  - Wrap: ptr=MEM_DEPTH-1 increments to 0.
  - Unbounded word count per frame.
  - If SS_n rises with 1..DATA_WIDTH-1 bits of a word collected, the partial word is discarded (no write) and err pulses.
- Read burst:
  - k=ADDR_SIZE+2 is RD_TURN: synchronous RAM read of ptr is issued, and the MOSI bit is ignored.
  - At the edge ending RD_TURN, MISO takes word[DATA_WIDTH-1]. Each subsequent edge shifts out the next bit.
  - During the cycle a word's last bit is on MISO, the RAM reads ptr+1 (wrapped). On the next edge, the new word's MSB appears with no gap.
  - MOSI is ignored in RD_DATA. Ending a read mid-word is legal and does not raise err.
- MISO is 0 in every state except RD_DATA, and returns to 0 on the edge that returns to IDLE.
- Address ≥ MEM_DEPTH (possible when MEM_DEPTH < 2**ADDR_SIZE): the start address is taken modulo MEM_DEPTH, i.e. ptr is loaded with addr mod MEM_DEPTH.
- The RAM is single-port: a read and a write never occur in the same cycle, since modes are exclusive per frame.

Decomposition:
- Package spi_ram_pkg holds:
  - the cmd localparams (CMD_WR_BURST=2'b00, CMD_RD_BURST=2'b01);
  - the state encoding constants;
  - the CMD_LEN=2 constant.
- Sub-module spi_ram_sp: single-port synchronous RAM (we, addr, din, re, dout registered; MEM_DEPTH×DATA_WIDTH, no reset on the array).
- The top level holds the FSM, bit counter, shift registers and address pointer.

Test Plan:
- Single write then read: defaults; frame 00, addr 0x10, data 0xA5; SS_n high; then frame 01, addr 0x10.
  - Expect MISO bits 1,0,1,0,0,1,0,1 on the 8 edges after RD_TURN.
  - busy high for the whole of each frame.
- Burst write with wrap: write addr 0xFE, words 0x11,0x22,0x33. Read burst from 0xFE for 3 words.
  - Expect 0x11,0x22,0x33, with mem[0xFF]=0x22 and mem[0x00]=0x33.
  - Back-to-back words on MISO with no idle bit.
- Aborted word: write addr 0x05, word 0x3C, then 3 bits of a second word, then SS_n=1.
  - Expect err pulse of exactly 1 cycle; mem[0x06] unchanged; mem[0x05]=0x3C.
- Reserved cmd: frame 11 followed by 20 MOSI toggles.
  - Expect err pulse one edge after cmd complete; no RAM write; MISO stays 0; IDLE on SS_n=1.
- Reset mid-read: during RD_DATA, rst=1 for 2 cycles.
  - Expect MISO=0 and busy=0 immediately (asynchronous).
  - With SS_n still low after release, state stays IDLE.
  - Next full frame works normally.
- Parameter sweep: ADDR_SIZE=4, DATA_WIDTH=16, MEM_DEPTH=12.
  - Write addr 13 → lands at 1 (13 mod 12).
  - Burst from 11 wraps to 0.
  - Read back 16-bit words 0xBEEF, 0x1234 bit-exact.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared constants and state encoding for the SPI burst RAM slave.
package spi_ram_pkg;

  localparam int unsigned CMD_LEN = 2;

  localparam logic [CMD_LEN-1:0] CMD_WR_BURST = 2'b00;
  localparam logic [CMD_LEN-1:0] CMD_RD_BURST = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_RD_TURN = 3'd4,
    ST_RD_DATA = 3'd5,
    ST_IGNORE  = 3'd6
  } state_t;

endpackage

// File: rtl/spi_ram_burst_slave_if.sv
// Pin-level SPI slave bundle: select, serial data in/out and status flags.
interface spi_ram_burst_slave_if;

  logic SS_n;
  logic MOSI;
  logic MISO;
  logic busy;
  logic err;

  modport slave (
    input  SS_n,
    input  MOSI,
    output MISO,
    output busy,
    output err
  );

  modport master (
    output SS_n,
    output MOSI,
    input  MISO,
    input  busy,
    input  err
  );

endinterface

// File: rtl/spi_ram_sp.sv
// Single-port synchronous RAM with registered read data; array is not reset.
module spi_ram_sp #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_din;
    end
    if (i_re) begin
      r_dout <= r_mem[i_addr];
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/spi_ram_burst_slave.sv
// SPI slave on the system clock: framed burst write/read into a single-port RAM
// with auto-incrementing, wrapping address pointer and error flagging.
module spi_ram_burst_slave
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_ram_burst_slave_if.slave  bus
);

  localparam int unsigned MAX_AD  = (ADDR_SIZE > DATA_WIDTH) ? ADDR_SIZE : DATA_WIDTH;
  localparam int unsigned MAX_LEN = (MAX_AD > CMD_LEN) ? MAX_AD : CMD_LEN;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_CMD_LAST  = CNT_W'(CMD_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_WORD_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_WORD      = CNT_W'(DATA_WIDTH);
  localparam logic [ADDR_SIZE-1:0] PTR_LAST  = ADDR_SIZE'(MEM_DEPTH - 1);

  function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
    return (p == PTR_LAST) ? '0 : p + ADDR_SIZE'(1);
  endfunction

  state_t                  r_state, w_state_nx;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nx;
  logic [CMD_LEN-1:0]      r_cmd, w_cmd_nx;
  logic [ADDR_SIZE-2:0]    r_addr, w_addr_nx;
  logic [ADDR_SIZE-1:0]    r_ptr, w_ptr_nx;
  logic [DATA_WIDTH-2:0]   r_wsh, w_wsh_nx;
  logic [DATA_WIDTH-1:0]   r_rsh, w_rsh_nx;
  logic                    r_miso, w_miso_nx;
  logic                    r_err, w_err_nx;
  logic                    r_busy;
  logic                    r_ss_prev;

  logic                    w_we, w_re;
  logic [ADDR_SIZE-1:0]    w_ram_addr;
  logic [DATA_WIDTH-1:0]   w_ram_din;
  logic [DATA_WIDTH-1:0]   w_ram_dout;
  logic [ADDR_SIZE-1:0]    w_start;
  logic [ADDR_SIZE-1:0]    w_start_mod;

  assign w_start     = {r_addr, bus.MOSI};
  assign w_start_mod = ADDR_SIZE'(32'(w_start) % MEM_DEPTH);
  assign w_ram_din   = {r_wsh, bus.MOSI};

  spi_ram_sp #(
    .ADDR_W (ADDR_SIZE),
    .DATA_W (DATA_WIDTH),
    .DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_re   (w_re),
    .i_addr (w_ram_addr),
    .i_din  (w_ram_din),
    .o_dout (w_ram_dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state, datapath and RAM control; SS_n high overrides every state.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_cmd_nx   = r_cmd;
    w_addr_nx  = r_addr;
    w_ptr_nx   = r_ptr;
    w_wsh_nx   = r_wsh;
    w_rsh_nx   = r_rsh;
    w_miso_nx  = 1'b0;
    w_err_nx   = 1'b0;
    w_we       = 1'b0;
    w_re       = 1'b0;
    w_ram_addr = r_ptr;

    if (bus.SS_n) begin
      w_state_nx = ST_IDLE;
      w_cnt_nx   = '0;
      w_err_nx   = (r_state == ST_WR_DATA) && (r_cnt != '0);
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (r_ss_prev) begin
            w_state_nx = ST_CMD;
            w_cmd_nx   = {1'b0, bus.MOSI};
            w_cnt_nx   = CNT_ONE;
          end
        end
        ST_CMD: begin
          w_cmd_nx = {r_cmd[0], bus.MOSI};
          w_cnt_nx = r_cnt + CNT_ONE;
          if (r_cnt == CNT_CMD_LAST) begin
            w_cnt_nx   = '0;
            w_state_nx = (w_cmd_nx == CMD_WR_BURST || w_cmd_nx == CMD_RD_BURST) ?
                         ST_ADDR : ST_IGNORE;
          end
        end
        ST_ADDR: begin
          w_addr_nx = w_start[ADDR_SIZE-2:0];
          w_cnt_nx  = r_cnt + CNT_ONE;
          if (r_cnt == CNT_ADDR_LAST) begin
            w_cnt_nx = '0;
            w_ptr_nx = w_start_mod;
            if (r_cmd == CMD_RD_BURST) begin
              // Fetch the first word now so its MSB is ready when the turnaround ends.
              w_state_nx = ST_RD_TURN;
              w_re       = 1'b1;
              w_ram_addr = w_start_mod;
            end else begin
              w_state_nx = ST_WR_DATA;
            end
          end
        end
        ST_WR_DATA: begin
          w_wsh_nx = w_ram_din[DATA_WIDTH-2:0];
          w_cnt_nx = r_cnt + CNT_ONE;
          if (r_cnt == CNT_WORD_LAST) begin
            w_we     = 1'b1;
            w_ptr_nx = ptr_inc(r_ptr);
            w_cnt_nx = '0;
          end
        end
        ST_RD_TURN: begin
          w_state_nx = ST_RD_DATA;
          w_miso_nx  = w_ram_dout[DATA_WIDTH-1];
          w_rsh_nx   = {w_ram_dout[DATA_WIDTH-2:0], 1'b0};
          w_cnt_nx   = CNT_ONE;
        end
        ST_RD_DATA: begin
          // Prefetch the following word one cycle early for a gapless bit stream.
          if (r_cnt == CNT_WORD_LAST) begin
            w_re       = 1'b1;
            w_ram_addr = ptr_inc(r_ptr);
          end
          if (r_cnt == CNT_WORD) begin
            w_miso_nx = w_ram_dout[DATA_WIDTH-1];
            w_rsh_nx  = {w_ram_dout[DATA_WIDTH-2:0], 1'b0};
            w_ptr_nx  = ptr_inc(r_ptr);
            w_cnt_nx  = CNT_ONE;
          end else begin
            w_miso_nx = r_rsh[DATA_WIDTH-1];
            w_rsh_nx  = {r_rsh[DATA_WIDTH-2:0], 1'b0};
            w_cnt_nx  = r_cnt + CNT_ONE;
          end
        end
        ST_IGNORE: begin
          if (r_cnt == '0) begin
            w_err_nx = 1'b1;
            w_cnt_nx = CNT_ONE;
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_cmd     <= '0;
      r_addr    <= '0;
      r_ptr     <= '0;
      r_wsh     <= '0;
      r_rsh     <= '0;
      r_miso    <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_ss_prev <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nx;
      r_cmd     <= w_cmd_nx;
      r_addr    <= w_addr_nx;
      r_ptr     <= w_ptr_nx;
      r_wsh     <= w_wsh_nx;
      r_rsh     <= w_rsh_nx;
      r_miso    <= w_miso_nx;
      r_err     <= w_err_nx;
      r_busy    <= (w_state_nx != ST_IDLE);
      r_ss_prev <= bus.SS_n;
    end
  end

  assign bus.MISO = r_miso;
  assign bus.busy = r_busy;
  assign bus.err  = r_err;

endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// Randomized bench for spi_ram_burst_slave: default and swept-parameter instances
// checked against an array memory model and a per-edge frame expectation.
module tb_spi_ram_burst_slave;

  logic clk = 1'b0;
  logic rst0, rst1;

  spi_ram_burst_slave_if bus0 ();
  spi_ram_burst_slave_if bus1 ();

  spi_ram_burst_slave u_dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0.slave)
  );

  spi_ram_burst_slave #(
    .ADDR_SIZE  (4),
    .DATA_WIDTH (16),
    .MEM_DEPTH  (12)
  ) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_mem [2][256];
  bit pay [$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int p_a(input int sel);   return (sel != 0) ? 4  : 8;   endfunction
  function automatic int p_d(input int sel);   return (sel != 0) ? 16 : 8;   endfunction
  function automatic int p_dep(input int sel); return (sel != 0) ? 12 : 256; endfunction

  task automatic drive(input int sel, input bit ss, input bit mosi);
    if (sel == 0) begin bus0.SS_n = ss; bus0.MOSI = mosi; end
    else          begin bus1.SS_n = ss; bus1.MOSI = mosi; end
  endtask

  task automatic sample(input int sel, output int miso, output int err, output int busy);
    if (sel == 0) begin miso = int'(bus0.MISO); err = int'(bus0.err); busy = int'(bus0.busy); end
    else          begin miso = int'(bus1.MISO); err = int'(bus1.err); busy = int'(bus1.busy); end
  endtask

  task automatic push_word(input int w, input int d);
    for (int i = d - 1; i >= 0; i--) pay.push_back(bit'((w >> i) & 1));
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) pay.push_back(bit'($urandom & 1));
  endtask

  // One complete frame: cmd, address, then the bits queued in pay.
  task automatic do_frame(input int sel, input bit [1:0] cmd, input int addr, input string tag);
    int a, d, dep, start, miso, err, busy, j, w, exp_miso, nfull;
    bit bits [$];
    a = p_a(sel); d = p_d(sel); dep = p_dep(sel);
    start = addr % dep;
    bits.push_back(cmd[1]);
    bits.push_back(cmd[0]);
    for (int i = a - 1; i >= 0; i--) bits.push_back(bit'((addr >> i) & 1));
    foreach (pay[i]) bits.push_back(pay[i]);

    @(negedge clk); drive(sel, 1'b1, 1'b0);
    for (int k = 0; k < bits.size(); k++) begin
      @(negedge clk); drive(sel, 1'b0, bits[k]);
      @(posedge clk); #1;
      sample(sel, miso, err, busy);
      exp_miso = 0;
      if (cmd == 2'b01 && k >= a + 2) begin
        j = k - a - 2;
        w = (start + j / d) % dep;
        exp_miso = (exp_mem[sel][w] >> (d - 1 - j % d)) & 1;
      end
      check({tag, "_busy"}, busy, 1);
      check({tag, "_err"}, err, (cmd[1] && k == 2) ? 1 : 0);
      check({tag, "_miso"}, miso, exp_miso);
    end

    if (cmd == 2'b00) begin
      nfull = pay.size() / d;
      for (int i = 0; i < nfull; i++) begin
        w = 0;
        for (int b = 0; b < d; b++) w = (w << 1) | int'(pay[i * d + b]);
        exp_mem[sel][(start + i) % dep] = w;
      end
    end

    @(negedge clk); drive(sel, 1'b1, 1'b0);
    @(posedge clk); #1;
    sample(sel, miso, err, busy);
    check({tag, "_end_busy"}, busy, 0);
    check({tag, "_end_miso"}, miso, 0);
    check({tag, "_end_err"}, err, (cmd == 2'b00 && (pay.size() % d) != 0) ? 1 : 0);
    @(posedge clk); #1;
    sample(sel, miso, err, busy);
    check({tag, "_err_width"}, err, 0);
    pay.delete();
  endtask

  initial begin
    int miso, err, busy, sel, r, addr, n, mask;
    bit [1:0] cmd;
    bit rbits [$];

    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b1, 1'b0);
    drive(1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sample(s, miso, err, busy);
      check("reset_miso", miso, 0);
      check("reset_err", err, 0);
      check("reset_busy", busy, 0);
    end
    @(negedge clk); rst0 = 1'b0; rst1 = 1'b0;

    // Fill each RAM through a wrapping burst so every word is known to the model.
    for (int s = 0; s < 2; s++) begin
      mask = (1 << p_d(s)) - 1;
      for (int i = 0; i < p_dep(s); i++) push_word(int'($urandom) & mask, p_d(s));
      do_frame(s, 2'b00, int'($urandom_range(0, (1 << p_a(s)) - 1)), "fill");
    end

    push_word('hA5, 8);             do_frame(0, 2'b00, 'h10, "wr10");
    push_rand(9);                   do_frame(0, 2'b01, 'h10, "rd10");

    push_word('h11, 8); push_word('h22, 8); push_word('h33, 8);
    do_frame(0, 2'b00, 'hFE, "wr_wrap");
    push_rand(25);                  do_frame(0, 2'b01, 'hFE, "rd_wrap");
    push_rand(9);                   do_frame(0, 2'b01, 'hFF, "rd_ff");

    push_word('h3C, 8); push_rand(3);
    do_frame(0, 2'b00, 'h05, "abort");
    push_rand(17);                  do_frame(0, 2'b01, 'h05, "rd_abort");

    for (int i = 0; i < 20; i++) pay.push_back(bit'(i & 1));
    do_frame(0, 2'b11, 'h55, "rsvd");
    push_rand(9);                   do_frame(0, 2'b01, 'h10, "rd_after_rsvd");

    // Reset while streaming 0xA5 from 0x10: MSB is on MISO when rst rises.
    rbits = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    @(negedge clk); drive(0, 1'b1, 1'b0);
    foreach (rbits[k]) begin
      @(negedge clk); drive(0, 1'b0, rbits[k]);
      @(posedge clk);
    end
    #1;
    sample(0, miso, err, busy);
    check("rst_pre_miso", miso, 1);
    check("rst_pre_busy", busy, 1);
    #1 rst0 = 1'b1;
    #1;
    sample(0, miso, err, busy);
    check("rst_async_miso", miso, 0);
    check("rst_async_busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); drive(0, 1'b0, bit'(i & 1));
      @(posedge clk); #1;
      sample(0, miso, err, busy);
      check("rst_hold_busy", busy, 0);
      check("rst_hold_miso", miso, 0);
      check("rst_hold_err", err, 0);
    end
    push_rand(17);                  do_frame(0, 2'b01, 'h10, "rd_after_rst");

    push_word('hBEEF, 16);          do_frame(1, 2'b00, 13, "sw_wr13");
    push_word('h1234, 16); push_word('h5678, 16);
    do_frame(1, 2'b00, 11, "sw_wr11");
    push_rand(17);                  do_frame(1, 2'b01, 13, "sw_rd13");
    push_rand(17);                  do_frame(1, 2'b01, 1, "sw_rd1");
    push_rand(49);                  do_frame(1, 2'b01, 11, "sw_rd11");

    for (int it = 0; it < 40; it++) begin
      sel  = int'($urandom_range(0, 1));
      r    = int'($urandom_range(0, 7));
      addr = int'($urandom_range(0, (1 << p_a(sel)) - 1));
      if (r < 4) begin
        cmd = 2'b00;
        n   = int'($urandom_range(0, 4 * p_d(sel) - 1));
      end else if (r < 7) begin
        cmd = 2'b01;
        n   = int'($urandom_range(1, 3 * p_d(sel) + 1));
      end else begin
        cmd = {1'b1, 1'($urandom & 1)};
        n   = int'($urandom_range(0, 12));
      end
      push_rand(n);
      do_frame(sel, cmd, addr, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
